// File: rtl/rgbw_cmd_decoder_if.sv
// Byte-stream link from the SPI slave byte receiver into the RGBW command decoder.
interface rgbw_cmd_decoder_if;
  logic       cs;
  logic       byte_valid;
  logic [7:0] byte_data;

  modport master (output cs, byte_valid, byte_data);
  modport slave  (input  cs, byte_valid, byte_data);
endinterface

// File: rtl/rgbw_cmd_decoder.sv
// Parses SPI command frames into shadow registers and commits R/G/B/W/master atomically.
// Define CHECKSUM_EN to require a trailing XOR checksum byte on every valid frame.
module rgbw_cmd_decoder #(
  parameter logic [7:0] CH_RESET     = 8'h00,
  parameter logic [7:0] MASTER_RESET = 8'hFF
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  rgbw_cmd_decoder_if.slave   bus,
  output logic [7:0]          red_o,
  output logic [7:0]          green_o,
  output logic [7:0]          blue_o,
  output logic [7:0]          white_o,
  output logic [7:0]          master_o,
  output logic                update_o,
  output logic                frame_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_SKIP
`ifdef CHECKSUM_EN
    , S_CHECK
`endif
  } state_e;

  typedef enum logic [1:0] {OP_CH, OP_ALL, OP_MASTER} op_e;

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [1:0] ch_q, ch_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] shadow_q [4];
  logic [7:0] shadow_d [4];
  logic [7:0] red_q, red_d, green_q, green_d, blue_q, blue_d, white_q, white_d;
  logic [7:0] master_q, master_d;
  logic       update_q, update_d, err_q, err_d;
  logic       commit;
`ifdef CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  // Only bits [1:0] of a WR_CH command select the channel; [4:2] are don't-care.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^bus.byte_data[4:2];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    red_d    = red_q;
    green_d  = green_q;
    blue_d   = blue_q;
    white_d  = white_q;
    master_d = master_q;
    update_d = 1'b0;
    err_d    = 1'b0;
    commit   = 1'b0;
`ifdef CHECKSUM_EN
    csum_d   = csum_q;
`endif

    if (bus.cs) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      idx_d    = '0;
      shadow_d = '{default: '0};
      err_d    = (state_q == S_PAYLOAD);
`ifdef CHECKSUM_EN
      csum_d   = '0;
      if (state_q == S_CHECK) err_d = 1'b1;
`endif
    end else if (bus.byte_valid) begin
      case (state_q)
        S_IDLE: begin
          idx_d   = '0;
          state_d = S_PAYLOAD;
`ifdef CHECKSUM_EN
          csum_d  = bus.byte_data;
`endif
          case (bus.byte_data[7:5])
            3'b001: begin op_d = OP_CH;     ch_d = bus.byte_data[1:0]; cnt_d = 3'd1; end
            3'b010: begin op_d = OP_ALL;    cnt_d = 3'd4; end
            3'b011: begin op_d = OP_MASTER; cnt_d = 3'd1; end
            default: begin err_d = 1'b1; state_d = S_SKIP; end
          endcase
        end
        S_PAYLOAD: begin
          shadow_d[idx_q] = bus.byte_data;
          idx_d           = idx_q + 2'd1;
          cnt_d           = cnt_q - 3'd1;
`ifdef CHECKSUM_EN
          csum_d          = csum_q ^ bus.byte_data;
          if (cnt_q == 3'd1) state_d = S_CHECK;
`else
          if (cnt_q == 3'd1) begin
            commit  = 1'b1;
            state_d = S_SKIP;
          end
`endif
        end
`ifdef CHECKSUM_EN
        S_CHECK: begin
          if (bus.byte_data == csum_q) commit = 1'b1;
          else                         err_d  = 1'b1;
          state_d = S_SKIP;
        end
`endif
        default: ;
      endcase
    end

    // Commit reads shadow_d so the final payload byte lands in the same edge that samples it.
    if (commit) begin
      update_d = 1'b1;
      case (op_q)
        OP_CH: begin
          case (ch_q)
            2'd0:    red_d   = shadow_d[0];
            2'd1:    green_d = shadow_d[0];
            2'd2:    blue_d  = shadow_d[0];
            default: white_d = shadow_d[0];
          endcase
        end
        OP_ALL: begin
          red_d   = shadow_d[0];
          green_d = shadow_d[1];
          blue_d  = shadow_d[2];
          white_d = shadow_d[3];
        end
        OP_MASTER: master_d = shadow_d[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      op_q     <= OP_CH;
      ch_q     <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '{default: '0};
      red_q    <= CH_RESET;
      green_q  <= CH_RESET;
      blue_q   <= CH_RESET;
      white_q  <= CH_RESET;
      master_q <= MASTER_RESET;
      update_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
      white_q  <= white_d;
      master_q <= master_d;
      update_q <= update_d;
      err_q    <= err_d;
`ifdef CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign red_o       = red_q;
  assign green_o     = green_q;
  assign blue_o      = blue_q;
  assign white_o     = white_q;
  assign master_o    = master_q;
  assign update_o    = update_q;
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_rgbw_cmd_decoder.sv
// Directed bench for rgbw_cmd_decoder; adds checksum bytes when CHECKSUM_EN is defined.
module tb_rgbw_cmd_decoder;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] red, green, blue, white, master;
  logic       update, frame_err;
  int         total = 0;
  int         bad = 0;

  rgbw_cmd_decoder_if bus ();

  rgbw_cmd_decoder #(.CH_RESET(8'h00), .MASTER_RESET(8'hFF)) dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .bus        (bus),
    .red_o      (red),
    .green_o    (green),
    .blue_o     (blue),
    .white_o    (white),
    .master_o   (master),
    .update_o   (update),
    .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.cs = 1'b0;
  endtask

  task automatic cs_high();
    @(negedge clk);
    bus.cs = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.cs = 1'b1; bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (red !== 8'h00)     begin bad++; $display("FAIL reset_red: got %h want 00", red); end
    total++; if (green !== 8'h00)   begin bad++; $display("FAIL reset_green: got %h want 00", green); end
    total++; if (blue !== 8'h00)    begin bad++; $display("FAIL reset_blue: got %h want 00", blue); end
    total++; if (white !== 8'h00)   begin bad++; $display("FAIL reset_white: got %h want 00", white); end
    total++; if (master !== 8'hFF)  begin bad++; $display("FAIL reset_master: got %h want FF", master); end
    total++; if (update !== 1'b0)   begin bad++; $display("FAIL reset_update: got %b want 0", update); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", frame_err); end
  endtask

  task automatic test_wr_ch();
    cs_low();
    send_byte(8'h22);
    total++; if (update !== 1'b0) begin bad++; $display("FAIL wrch_early_update: got %b want 0", update); end
    send_byte(8'h80);
`ifdef CHECKSUM_EN
    total++; if (blue !== 8'h00) begin bad++; $display("FAIL wrch_precheck_blue: got %h want 00", blue); end
    send_byte(8'h22 ^ 8'h80);
`endif
    total++; if (update !== 1'b1) begin bad++; $display("FAIL wrch_update: got %b want 1", update); end
    total++; if (blue !== 8'h80)  begin bad++; $display("FAIL wrch_blue: got %h want 80", blue); end
    total++; if ({red, green, white} !== 24'h000000) begin bad++; $display("FAIL wrch_others: got %h want 000000", {red, green, white}); end
    total++; if (master !== 8'hFF) begin bad++; $display("FAIL wrch_master: got %h want FF", master); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL wrch_err: got %b want 0", frame_err); end
    @(negedge clk);
    total++; if (update !== 1'b0) begin bad++; $display("FAIL wrch_pulse_width: got %b want 0", update); end
    send_byte(8'h99);
    total++; if (update !== 1'b0 || blue !== 8'h80) begin bad++; $display("FAIL wrch_skip: got upd=%b blue=%h want upd=0 blue=80", update, blue); end
    cs_high();
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL wrch_cs_in_skip: got %b want 0", frame_err); end
  endtask

  task automatic test_wr_all();
    cs_low();
    send_byte(8'h40);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    total++; if (red !== 8'h00) begin bad++; $display("FAIL wrall_early_red: got %h want 00", red); end
    send_byte(8'h44);
`ifdef CHECKSUM_EN
    send_byte(8'h40 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
`endif
    total++; if ({red, green, blue, white} !== 32'h11223344) begin bad++; $display("FAIL wrall_rgbw: got %h want 11223344", {red, green, blue, white}); end
    total++; if (update !== 1'b1) begin bad++; $display("FAIL wrall_update: got %b want 1", update); end
    total++; if (master !== 8'hFF) begin bad++; $display("FAIL wrall_master: got %h want FF", master); end
    cs_high();
  endtask

  task automatic test_truncated();
    cs_low();
    send_byte(8'h40);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    bus.cs = 1'b1;
    @(negedge clk);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL trunc_err: got %b want 1", frame_err); end
    total++; if (update !== 1'b0) begin bad++; $display("FAIL trunc_update: got %b want 0", update); end
    total++; if ({red, green, blue, white} !== 32'h11223344) begin bad++; $display("FAIL trunc_rgbw: got %h want 11223344", {red, green, blue, white}); end
    @(negedge clk);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL trunc_pulse_width: got %b want 0", frame_err); end
  endtask

  task automatic test_invalid();
    cs_low();
    send_byte(8'hE0);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL inv_err: got %b want 1", frame_err); end
    send_byte(8'h55);
    total++; if (frame_err !== 1'b0 || update !== 1'b0) begin bad++; $display("FAIL inv_skip: got err=%b upd=%b want 0 0", frame_err, update); end
    cs_high();
    cs_low();
    send_byte(8'h60);
    send_byte(8'h7F);
`ifdef CHECKSUM_EN
    send_byte(8'h60 ^ 8'h7F);
`endif
    total++; if (master !== 8'h7F) begin bad++; $display("FAIL inv_master: got %h want 7F", master); end
    total++; if (update !== 1'b1) begin bad++; $display("FAIL inv_master_update: got %b want 1", update); end
    cs_high();
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    cs_low();
    send_byte(8'h60);
    send_byte(8'h10);
    send_byte(8'h00);
    total++; if (frame_err !== 1'b1 || update !== 1'b0) begin bad++; $display("FAIL csum_bad: got err=%b upd=%b want 1 0", frame_err, update); end
    total++; if (master !== 8'h7F) begin bad++; $display("FAIL csum_bad_master: got %h want 7F", master); end
    cs_high();
    cs_low();
    send_byte(8'h60);
    send_byte(8'h10);
    send_byte(8'h70);
    total++; if (master !== 8'h10 || update !== 1'b1) begin bad++; $display("FAIL csum_good: got m=%h upd=%b want 10 1", master, update); end
    cs_high();
  endtask
`endif

  task automatic test_back_to_back();
    cs_low();
    @(negedge clk);
    bus.byte_valid = 1'b1; bus.byte_data = 8'h21;
    @(negedge clk);
    bus.byte_data = 8'hAB;
`ifdef CHECKSUM_EN
    @(negedge clk);
    bus.byte_data = 8'h21 ^ 8'hAB;
`endif
    @(negedge clk);
    bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
    total++; if (green !== 8'hAB || update !== 1'b1) begin bad++; $display("FAIL b2b_green: got g=%h upd=%b want AB 1", green, update); end
    total++; if ({red, blue, white} !== 24'h113344) begin bad++; $display("FAIL b2b_others: got %h want 113344", {red, blue, white}); end
    @(negedge clk);
    total++; if (update !== 1'b0) begin bad++; $display("FAIL b2b_pulse_width: got %b want 0", update); end
    cs_high();
  endtask

  initial begin
    test_reset();
    test_wr_ch();
    test_wr_all();
    test_truncated();
    test_invalid();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
